// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port owner: merges ALU, LSU and MDU results onto a single registered
// write port and tracks long-latency destinations in a busy-bit scoreboard.
module regfile_wb_arbiter #(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            alu_valid_i,
   input  logic [AW-1:0]   alu_rd_addr_i,
   input  logic [XLEN-1:0] alu_rd_data_i,
   input  logic            lsu_valid_i,
   output logic            lsu_ready_o,
   input  logic [AW-1:0]   lsu_rd_addr_i,
   input  logic [XLEN-1:0] lsu_rd_data_i,
   input  logic            mdu_valid_i,
   output logic            mdu_ready_o,
   input  logic [AW-1:0]   mdu_rd_addr_i,
   input  logic [XLEN-1:0] mdu_rd_data_i,
   input  logic            issue_valid_i,
   input  logic [AW-1:0]   issue_rd_i,
   output logic            issue_ready_o,
   input  logic [AW-1:0]   rs1_addr_i,
   input  logic [AW-1:0]   rs2_addr_i,
   output logic            rs1_busy_o,
   output logic            rs2_busy_o,
   output logic            rd_wren_o,
   output logic [AW-1:0]   rd_addr_o,
   output logic [XLEN-1:0] rd_data_o
);

   // Handshake: a slow source holds valid/addr/data stable until ready; a transfer
   // happens on any edge where valid & ready, and ready is never raised without valid.
   logic            r_wren;
   logic [AW-1:0]   r_addr;
   logic [XLEN-1:0] r_data;
   logic            r_from_slow;
   logic            r_last_mdu;
   logic [NREG-1:1] r_busy;

   logic            w_lsu_grant;
   logic            w_mdu_grant;
   logic            w_accept;
   logic            w_sel_slow;
   logic [AW-1:0]   w_sel_addr;
   logic [XLEN-1:0] w_sel_data;
   logic [NREG-1:0] w_busy_full;
   logic            w_issue_fire;
   logic            w_clear;
   logic [NREG-1:1] w_busy_nx;

   assign w_lsu_grant = ~rst_i & ~alu_valid_i & lsu_valid_i & (~mdu_valid_i | r_last_mdu);
   assign w_mdu_grant = ~rst_i & ~alu_valid_i & mdu_valid_i & (~lsu_valid_i | ~r_last_mdu);
   assign w_accept    = alu_valid_i | w_lsu_grant | w_mdu_grant;

   assign lsu_ready_o = w_lsu_grant;
   assign mdu_ready_o = w_mdu_grant;

   always_comb begin
      w_sel_slow = 1'b0;
      w_sel_addr = alu_rd_addr_i;
      w_sel_data = alu_rd_data_i;
      if (!alu_valid_i && w_lsu_grant) begin
         w_sel_slow = 1'b1;
         w_sel_addr = lsu_rd_addr_i;
         w_sel_data = lsu_rd_data_i;
      end else if (!alu_valid_i && w_mdu_grant) begin
         w_sel_slow = 1'b1;
         w_sel_addr = mdu_rd_addr_i;
         w_sel_data = mdu_rd_data_i;
      end
   end

   // Bit 0 is hardwired clear so x0 always reads idle and is always issuable.
   assign w_busy_full   = {r_busy, 1'b0};
   assign issue_ready_o = ~w_busy_full[issue_rd_i];
   assign rs1_busy_o    = w_busy_full[rs1_addr_i];
   assign rs2_busy_o    = w_busy_full[rs2_addr_i];

   assign w_issue_fire = issue_valid_i & issue_ready_o & (issue_rd_i != '0);
   assign w_clear      = r_wren & r_from_slow;

   // Clear is applied before set so a same-edge set on the same register wins.
   always_comb begin
      w_busy_nx = r_busy;
      for (int i = 1; i < NREG; i++) begin
         if (w_clear && r_addr == AW'(i)) w_busy_nx[i] = 1'b0;
         if (w_issue_fire && issue_rd_i == AW'(i)) w_busy_nx[i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wren      <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_from_slow <= 1'b0;
         r_last_mdu  <= 1'b1;
         r_busy      <= '0;
      end else begin
         r_wren      <= w_accept & (w_sel_addr != '0);
         r_addr      <= w_sel_addr;
         r_data      <= w_sel_data;
         r_from_slow <= w_sel_slow & w_accept;
         if (w_lsu_grant)      r_last_mdu <= 1'b0;
         else if (w_mdu_grant) r_last_mdu <= 1'b1;
         r_busy      <= w_busy_nx;
      end
   end

   assign rd_wren_o = r_wren;
   assign rd_addr_o = r_addr;
   assign rd_data_o = r_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: per-cycle reference model of arbitration and scoreboard,
// expected writes queued at acceptance and compared one cycle later.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        alu_valid_i;
   logic [4:0]  alu_rd_addr_i;
   logic [31:0] alu_rd_data_i;
   logic        lsu_valid_i;
   logic        lsu_ready_o;
   logic [4:0]  lsu_rd_addr_i;
   logic [31:0] lsu_rd_data_i;
   logic        mdu_valid_i;
   logic        mdu_ready_o;
   logic [4:0]  mdu_rd_addr_i;
   logic [31:0] mdu_rd_data_i;
   logic        issue_valid_i;
   logic [4:0]  issue_rd_i;
   logic        issue_ready_o;
   logic [4:0]  rs1_addr_i;
   logic [4:0]  rs2_addr_i;
   logic        rs1_busy_o;
   logic        rs2_busy_o;
   logic        rd_wren_o;
   logic [4:0]  rd_addr_o;
   logic [31:0] rd_data_o;

   regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .alu_valid_i(alu_valid_i), .alu_rd_addr_i(alu_rd_addr_i), .alu_rd_data_i(alu_rd_data_i),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
      .lsu_rd_addr_i(lsu_rd_addr_i), .lsu_rd_data_i(lsu_rd_data_i),
      .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o),
      .mdu_rd_addr_i(mdu_rd_addr_i), .mdu_rd_data_i(mdu_rd_data_i),
      .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
      .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
      .rd_wren_o(rd_wren_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- slow-source drivers ----------------
   // entry: [36:32]=rd, [31:0]=data
   logic [36:0] lsu_q[$];
   logic [36:0] mdu_q[$];
   logic        m_lsu_acc = 1'b0;
   logic        m_mdu_acc = 1'b0;

   always @(posedge clk) begin
      #3;
      if (m_lsu_acc && lsu_q.size() > 0) void'(lsu_q.pop_front());
      if (m_mdu_acc && mdu_q.size() > 0) void'(mdu_q.pop_front());
      lsu_valid_i = (lsu_q.size() > 0);
      mdu_valid_i = (mdu_q.size() > 0);
      if (lsu_q.size() > 0) {lsu_rd_addr_i, lsu_rd_data_i} = lsu_q[0];
      if (mdu_q.size() > 0) {mdu_rd_addr_i, mdu_rd_data_i} = mdu_q[0];
   end

   // ---------------- reference model + scoreboard ----------------
   // exp entry: [39]=check addr/data always, [38]=from slow, [37]=wren, [36:32]=addr, [31:0]=data
   logic [39:0] exp_q[$];
   logic [39:0] e;
   logic [31:0] m_busy = '0;
   logic        m_last_mdu = 1'b1;
   logic        c_en, c_slow, g_lsu, g_mdu, m_iss_rdy;
   logic [4:0]  c_addr;

   always @(negedge clk) begin
      c_en = 1'b0; c_slow = 1'b0; c_addr = '0;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("rd_wren", {31'b0, rd_wren_o}, {31'b0, e[37]});
         if (e[37] || e[39]) begin
            check_eq("rd_addr", {27'b0, rd_addr_o}, {27'b0, e[36:32]});
            check_eq("rd_data", rd_data_o, e[31:0]);
         end
         c_en = e[37]; c_slow = e[38]; c_addr = e[36:32];
      end
      if (rst_i) begin
         check_eq("rst_lsu_ready", {31'b0, lsu_ready_o}, 32'd0);
         check_eq("rst_mdu_ready", {31'b0, mdu_ready_o}, 32'd0);
         m_busy = '0;
         m_last_mdu = 1'b1;
         m_lsu_acc = 1'b0;
         m_mdu_acc = 1'b0;
         exp_q.delete();
         exp_q.push_back({1'b1, 1'b0, 1'b0, 5'd0, 32'd0});
      end else begin
         g_lsu = !alu_valid_i && lsu_valid_i && (!mdu_valid_i || m_last_mdu);
         g_mdu = !alu_valid_i && mdu_valid_i && (!lsu_valid_i || !m_last_mdu);
         m_iss_rdy = (issue_rd_i == 5'd0) || !m_busy[issue_rd_i];
         check_eq("lsu_ready", {31'b0, lsu_ready_o}, {31'b0, g_lsu});
         check_eq("mdu_ready", {31'b0, mdu_ready_o}, {31'b0, g_mdu});
         check_eq("issue_ready", {31'b0, issue_ready_o}, {31'b0, m_iss_rdy});
         check_eq("rs1_busy", {31'b0, rs1_busy_o}, {31'b0, m_busy[rs1_addr_i]});
         check_eq("rs2_busy", {31'b0, rs2_busy_o}, {31'b0, m_busy[rs2_addr_i]});
         if (alu_valid_i)
            exp_q.push_back({1'b0, 1'b0, alu_rd_addr_i != 5'd0, alu_rd_addr_i, alu_rd_data_i});
         else if (g_lsu)
            exp_q.push_back({1'b0, 1'b1, lsu_rd_addr_i != 5'd0, lsu_rd_addr_i, lsu_rd_data_i});
         else if (g_mdu)
            exp_q.push_back({1'b0, 1'b1, mdu_rd_addr_i != 5'd0, mdu_rd_addr_i, mdu_rd_data_i});
         else
            exp_q.push_back(40'd0);
         if (g_lsu) m_last_mdu = 1'b0;
         if (g_mdu) m_last_mdu = 1'b1;
         if (c_en && c_slow) m_busy[c_addr] = 1'b0;
         if (issue_valid_i && m_iss_rdy && issue_rd_i != 5'd0) m_busy[issue_rd_i] = 1'b1;
         m_lsu_acc = g_lsu;
         m_mdu_acc = g_mdu;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic alu_drive(input logic v, input logic [4:0] rd, input logic [31:0] d);
      alu_valid_i = v; alu_rd_addr_i = rd; alu_rd_data_i = d;
   endtask

   task automatic issue_drive(input logic v, input logic [4:0] rd);
      issue_valid_i = v; issue_rd_i = rd;
   endtask

   initial begin
      rst_i = 1'b1;
      alu_drive(1'b0, 5'd0, 32'd0);
      issue_drive(1'b0, 5'd0);
      lsu_valid_i = 1'b0; lsu_rd_addr_i = '0; lsu_rd_data_i = '0;
      mdu_valid_i = 1'b0; mdu_rd_addr_i = '0; mdu_rd_data_i = '0;
      rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
      lsu_q.push_back({5'd4, 32'h0000_A5A5});
      step(2);

      // release with an ALU write; the held LSU load follows
      rst_i = 1'b0;
      alu_drive(1'b1, 5'd3, 32'hDEAD_BEEF);
      step();
      alu_drive(1'b0, 5'd0, 32'd0);
      step(2);
      mdu_q.push_back({5'd2, 32'h0000_0022});
      step(3);

      // ALU priority over both slow sources
      lsu_q.push_back({5'd10, 32'h1010_1010});
      mdu_q.push_back({5'd11, 32'h1111_1111});
      for (int i = 0; i < 3; i++) begin
         alu_drive(1'b1, 5'(i + 12), 32'hA000_0000 + i);
         step();
      end
      alu_drive(1'b0, 5'd0, 32'd0);
      step(4);

      // round-robin with both slow sources streaming
      for (int i = 0; i < 4; i++) begin
         lsu_q.push_back({5'd7, 32'h7000_0000 + i});
         mdu_q.push_back({5'd9, 32'h9000_0000 + i});
      end
      step(12);

      // scoreboard set, hazard visibility, clear timing
      rs1_addr_i = 5'd5; rs2_addr_i = 5'd5;
      issue_drive(1'b1, 5'd5);
      step();
      issue_drive(1'b0, 5'd0);
      step(3);
      mdu_q.push_back({5'd5, 32'h0000_1234});
      step();
      issue_drive(1'b1, 5'd5);
      step(2);
      issue_drive(1'b0, 5'd0);
      step(2);
      mdu_q.push_back({5'd5, 32'h0000_5678});
      step(4);

      // same-edge set and clear of x5
      lsu_q.push_back({5'd5, 32'h0000_0555});
      step();
      issue_drive(1'b1, 5'd5);
      step();
      issue_drive(1'b0, 5'd0);
      step(2);
      lsu_q.push_back({5'd5, 32'h0000_0556});
      step(4);

      // x0 handling
      rs2_addr_i = 5'd0;
      lsu_q.push_back({5'd0, 32'hFFFF_FFFF});
      issue_drive(1'b1, 5'd0);
      step();
      issue_drive(1'b0, 5'd0);
      step(3);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         alu_drive($urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), $urandom);
         if ($urandom_range(0, 2) == 0 && lsu_q.size() < 4)
            lsu_q.push_back({5'($urandom_range(0, 31)), 32'($urandom)});
         if ($urandom_range(0, 2) == 0 && mdu_q.size() < 4)
            mdu_q.push_back({5'($urandom_range(0, 31)), 32'($urandom)});
         issue_drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
         rs1_addr_i = 5'($urandom_range(0, 31));
         rs2_addr_i = 5'($urandom_range(0, 31));
         if (i == 150) rst_i = 1'b1;
         if (i == 152) rst_i = 1'b0;
         step();
      end
      alu_drive(1'b0, 5'd0, 32'd0);
      issue_drive(1'b0, 5'd0);

      // drain with a bounded wait
      begin
         int budget;
         budget = 0;
         while ((lsu_q.size() > 0 || mdu_q.size() > 0) && budget < 200) begin
            step();
            budget++;
         end
         check_eq("drain_timeout", {31'b0, (lsu_q.size() > 0 || mdu_q.size() > 0)}, 32'd0);
      end
      step(4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writer side of the integer register file. Owns the single regfile write port: rd_wren_o, rd_addr_o and rd_data_o.
- Merges three result sources onto that port:
  - ALU: single-cycle, no back-pressure.
  - LSU: load results, valid/ready.
  - MDU: multiply/divide results, valid/ready.
- Keeps a busy-bit scoreboard for long-latency destinations, so decode can stall on RAW and WAW hazards.

Parameters:
- XLEN, 32, data width of results and write port.
- NREG, 32, number of architectural registers. Address width is clog2(NREG) = 5.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- alu_valid_i  in  1  ALU result present this cycle.
- alu_rd_addr_i  in  5  ALU destination.
- alu_rd_data_i  in  XLEN  ALU result.
- lsu_valid_i  in  1  load result valid.
- lsu_ready_o  out  1  load result accepted this cycle.
- lsu_rd_addr_i  in  5  load destination.
- lsu_rd_data_i  in  XLEN  load data.
- mdu_valid_i  in  1  MDU result valid.
- mdu_ready_o  out  1  MDU result accepted this cycle.
- mdu_rd_addr_i  in  5  MDU destination.
- mdu_rd_data_i  in  XLEN  MDU result.
- issue_valid_i  in  1  long-latency op issued this cycle.
- issue_rd_i  in  5  its destination.
- issue_ready_o  out  1  issue_rd_i not busy; issue may proceed.
- rs1_addr_i  in  5  decode source 1.
- rs2_addr_i  in  5  decode source 2.
- rs1_busy_o  out  1  rs1 has a pending long-latency write.
- rs2_busy_o  out  1  rs2 has a pending long-latency write.
- rd_wren_o  out  1  regfile write enable.
- rd_addr_o  out  5  regfile write address.
- rd_data_o  out  XLEN  regfile write data.

Behaviour:
- Reset: rst_i is synchronous and active-high. On reset:
  - rd_wren_o=0, rd_addr_o=0, rd_data_o=0.
  - All busy bits cleared.
  - Round-robin pointer set to "MDU last", so LSU wins first.
  - lsu_ready_o=0 and mdu_ready_o=0 while rst_i=1.
  - Reset mid-operation discards any in-flight output-register write and all scoreboard state.
- Arbitration is per cycle and combinational:
  - Priority: ALU > {LSU, MDU}, with round-robin between LSU and MDU.
  - alu_valid_i=1: ALU takes the slot; lsu_ready_o=0 and mdu_ready_o=0.
  - Otherwise, if only one slow source is valid, it is granted.
  - If both slow sources are valid, the one not granted last is granted. The pointer updates on every slow grant.
  - A ready is never asserted without the matching valid.
  - A slow source holds valid, address and data stable until ready=1. Transfer occurs when valid & ready.
- Output register, 1-cycle latency: a result accepted in cycle N drives rd_wren_o/rd_addr_o/rd_data_o during cycle N+1. At most one write per cycle.
- x0 handling: a result with rd=0 is accepted (handshake completes), but rd_wren_o stays 0 and rd_addr_o/rd_data_o are don't-care. issue_rd_i=0 never sets a busy bit.
- No-grant cycle: rd_wren_o=0 in the following cycle.
- Scoreboard, busy[NREG-1:1]:
  - Set: at the clock edge where issue_valid_i & issue_ready_o & issue_rd_i!=0.
  - Clear: at the clock edge where rd_wren_o=1 for a slow-source write to that address (write commits to regfile). ALU writes never touch the scoreboard.
  - Same-edge set and clear of the same register: set wins.
- issue_ready_o = ~busy[issue_rd_i]; x0 is always ready. issue_valid_i while not ready is ignored.
- rs1_busy_o / rs2_busy_o = busy[rsN_addr_i], combinational; x0 reads 0.
- Timing example: LSU result for x5 accepted in cycle N → write in N+1 → rs*_busy_o for x5 drops in N+2.
- The output register tags each entry with a from_slow bit so the scoreboard clears only on LSU/MDU writes.

Test Plan:
- Reset checks: rst_i=1 for 2 cycles with lsu_valid_i=1 → lsu_ready_o=0, rd_wren_o=0. Then release with alu_valid_i=1, rd=3, data=0xDEADBEEF → next cycle rd_wren_o=1, rd_addr_o=3, rd_data_o=0xDEADBEEF.
- ALU priority: alu_valid_i, lsu_valid_i and mdu_valid_i all 1 for 3 cycles → both readys 0 throughout. Drop ALU → LSU granted, then MDU on the next cycle.
- Round-robin: LSU and MDU both continuously valid (rd=7 and rd=9) → writes alternate 7,9,7,9. Writes to x7/x9 appear on consecutive cycles after the first grant.
- Scoreboard: issue x5 → issue_ready_o for x5 = 0 and rs1_busy_o=1 with rs1_addr_i=5. MDU returns x5=0x1234 in cycle N → write in N+1 → busy clear in N+2. Re-issue to x5 in N+1 is blocked; in N+2 it is accepted.
- Same-edge set/clear: write to x5 committing while issue_valid_i of x5 lands on the same edge → busy[5] remains 1.
- x0 handling: LSU result rd=0, data=0xFFFFFFFF → lsu_ready_o=1, no rd_wren_o pulse. issue_rd_i=0 → issue_ready_o=1, no busy set. rs2_addr_i=0 → rs2_busy_o=0.
